// File: rtl/hwpe_ctrl_parity_monitor.sv
// Filters the regfile parity checker's fault flag, latches a sticky fault with an irq pulse and
// a saturating event count, and blocks job triggers unless the regfile is settled and clean.
module hwpe_ctrl_parity_monitor #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned FILTER_LEN    = 1,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 fault_detected_i,
  input  logic                 reg_write_i,
  input  logic                 trigger_i,
  input  logic                 clear_i,
  output logic                 trigger_o,
  output logic                 trigger_dropped_o,
  output logic                 fault_o,
  output logic                 irq_o,
  output logic                 armed_o,
  output logic [CNT_WIDTH-1:0] fault_cnt_o
);

  localparam int unsigned SettleW = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned FiltW   = $clog2(FILTER_LEN + 1);

  localparam logic [SettleW-1:0] SettleInit = SettleW'(SETTLE_CYCLES);
  localparam logic [SettleW-1:0] SettleOne  = SettleW'(1);
  localparam logic [FiltW-1:0]   FiltLast   = FiltW'(FILTER_LEN - 1);
  localparam logic [FiltW-1:0]   FiltOne    = FiltW'(1);

  if (SETTLE_CYCLES == 0) begin : gen_bad_settle
    $error("SETTLE_CYCLES must be >= 1");
  end
  if (FILTER_LEN == 0) begin : gen_bad_filter
    $error("FILTER_LEN must be >= 1");
  end
  if (CNT_WIDTH == 0) begin : gen_bad_cnt
    $error("CNT_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {StSettle, StCheck, StFault} state_e;

  state_e               state_q;
  logic [SettleW-1:0]   settle_cnt_q;
  logic [FiltW-1:0]     filt_cnt_q;
  logic                 irq_q;
  logic                 drop_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  // Only forward a trigger when parity is trusted and nothing disturbs the regfile this cycle.
  assign trigger_o = trigger_i & (state_q == StCheck) & ~fault_detected_i & ~reg_write_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StSettle;
      settle_cnt_q <= SettleInit;
      filt_cnt_q   <= '0;
      irq_q        <= 1'b0;
      drop_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      irq_q  <= 1'b0;
      drop_q <= trigger_i & ~trigger_o;
      unique case (state_q)
        StSettle: begin
          filt_cnt_q <= '0;
          if (reg_write_i) begin
            settle_cnt_q <= SettleInit;
          end else if (settle_cnt_q == SettleOne) begin
            state_q <= StCheck;
          end else begin
            settle_cnt_q <= settle_cnt_q - SettleOne;
          end
        end
        StCheck: begin
          if (reg_write_i) begin
            state_q      <= StSettle;
            settle_cnt_q <= SettleInit;
            filt_cnt_q   <= '0;
          end else if (fault_detected_i && (filt_cnt_q == FiltLast)) begin
            state_q    <= StFault;
            filt_cnt_q <= '0;
            irq_q      <= 1'b1;
            if (cnt_q != '1) begin
              cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
          end else if (fault_detected_i) begin
            filt_cnt_q <= filt_cnt_q + FiltOne;
          end else begin
            filt_cnt_q <= '0;
          end
        end
        StFault: begin
          if (clear_i) begin
            state_q      <= StSettle;
            settle_cnt_q <= SettleInit;
          end
        end
        default: begin
          state_q      <= StSettle;
          settle_cnt_q <= SettleInit;
          filt_cnt_q   <= '0;
        end
      endcase
    end
  end

  assign fault_o           = (state_q == StFault);
  assign armed_o           = (state_q == StCheck);
  assign irq_o             = irq_q;
  assign trigger_dropped_o = drop_q;
  assign fault_cnt_o       = cnt_q;

endmodule

// File: tb/tb_hwpe_ctrl_parity_monitor.sv
// Randomized bench for the parity monitor, checked cycle by cycle against a behavioural model
// phrased as "write-free cycles seen" and "consecutive flagged cycles" rather than FSM states.
module tb_hwpe_ctrl_parity_monitor;

  localparam int unsigned Settle = 2;
  localparam int unsigned Filter = 2;
  localparam int unsigned CntW   = 2;
  localparam int          CntMax = (1 << CntW) - 1;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            fault_detected_i = 1'b0;
  logic            reg_write_i = 1'b0;
  logic            trigger_i = 1'b0;
  logic            clear_i = 1'b0;
  logic            trigger_o;
  logic            trigger_dropped_o;
  logic            fault_o;
  logic            irq_o;
  logic            armed_o;
  logic [CntW-1:0] fault_cnt_o;

  hwpe_ctrl_parity_monitor #(
    .SETTLE_CYCLES(Settle),
    .FILTER_LEN   (Filter),
    .CNT_WIDTH    (CntW)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .fault_detected_i (fault_detected_i),
    .reg_write_i      (reg_write_i),
    .trigger_i        (trigger_i),
    .clear_i          (clear_i),
    .trigger_o        (trigger_o),
    .trigger_dropped_o(trigger_dropped_o),
    .fault_o          (fault_o),
    .irq_o            (irq_o),
    .armed_o          (armed_o),
    .fault_cnt_o      (fault_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit m_fault;
  int m_quiet;  // write-free edges since last write, clear or reset
  int m_run;    // consecutive trusted cycles with the flag high
  int m_cnt;
  bit m_irq;
  bit m_drop;
  int n_irq;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_armed();
    return !m_fault && (m_quiet >= Settle);
  endfunction

  function automatic bit m_trig();
    return trigger_i && m_armed() && !fault_detected_i && !reg_write_i;
  endfunction

  task automatic model_reset();
    m_fault = 0; m_quiet = 0; m_run = 0; m_cnt = 0; m_irq = 0; m_drop = 0;
  endtask

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_clock();
    bit armed;
    armed  = m_armed();
    m_drop = trigger_i && !m_trig();
    m_irq  = 0;
    if (m_fault) begin
      if (clear_i) begin
        m_fault = 0;
        m_quiet = 0;
      end
    end else if (reg_write_i) begin
      m_quiet = 0;
      m_run   = 0;
    end else if (!armed) begin
      m_quiet++;
      m_run = 0;
    end else if (fault_detected_i) begin
      m_run++;
      if (m_run == Filter) begin
        m_fault = 1;
        m_irq   = 1;
        m_run   = 0;
        m_cnt   = (m_cnt < CntMax) ? m_cnt + 1 : CntMax;
        n_irq++;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic check_outputs();
    check_eq("armed_o", int'(armed_o), int'(m_armed()));
    check_eq("fault_o", int'(fault_o), int'(m_fault));
    check_eq("irq_o", int'(irq_o), int'(m_irq));
    check_eq("trigger_dropped_o", int'(trigger_dropped_o), int'(m_drop));
    check_eq("fault_cnt_o", int'(fault_cnt_o), m_cnt);
    check_eq("trigger_o", int'(trigger_o), int'(m_trig()));
  endtask

  // One cycle: drive at the falling edge, check shortly after, then account for the rising edge.
  task automatic step(input int pw, input int pf, input int pt, input int pc);
    @(negedge clk_i);
    reg_write_i      = ($urandom_range(99) < pw);
    fault_detected_i = ($urandom_range(99) < pf);
    trigger_i        = ($urandom_range(99) < pt);
    clear_i          = ($urandom_range(99) < pc);
    #1;
    check_outputs();
    model_clock();
  endtask

  task automatic apply_reset();
    reg_write_i = 0; fault_detected_i = 0; trigger_i = 0; clear_i = 0;
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk_i);
    check_outputs();
    rst_ni = 1'b1;
    model_clock();
  endtask

  initial begin
    model_reset();
    n_irq = 0;
    #1 check_outputs();
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_clock();

    // Quiet start with occasional triggers: arming after reset and trigger forwarding.
    for (int i = 0; i < 6; i++) step(0, 0, 50, 0);
    // Mixed traffic at several write / fault / clear densities.
    for (int ph = 0; ph < 8; ph++) begin
      int pw, pf, pt, pc;
      pw = (ph % 4) * 10;
      pf = 30 + (ph % 3) * 25;
      pt = 40;
      pc = 5 + (ph % 2) * 25;
      for (int i = 0; i < 250; i++) step(pw, pf, pt, pc);
    end
    check_eq("counter saturated", m_cnt == CntMax ? int'(fault_cnt_o) : CntMax, CntMax);

    // Drive into FAULT without clearing, then reset asynchronously mid-operation.
    begin
      int budget = 300;
      while (!m_fault && budget > 0) begin
        step(5, 80, 30, 0);
        budget--;
      end
      check_eq("reach FAULT before reset", int'(fault_o), 1);
    end
    apply_reset();
    for (int i = 0; i < 6; i++) step(0, 0, 50, 0);
    for (int i = 0; i < 400; i++) step(10, 60, 40, 15);

    check_eq("irq pulses seen", n_irq > 4 ? 1 : 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hwpe_ctrl_parity_monitor.md
Name: hwpe_ctrl_parity_monitor

Overview:
- Sits directly downstream of the regfile parity checker. Consumes its registered fault_detected flag.
- Suppresses the transient parity mismatches that occur while software is still writing registers.
- Latches a sticky fault, raises an interrupt pulse, counts fault events, and gates the job trigger so that no job starts on a corrupted regfile.

Parameters:
SETTLE_CYCLES, 2, cycles after the last regfile write before parity is trusted (must be >= 1; covers the checker's 1-cycle output register)
FILTER_LEN, 1, consecutive trusted cycles with the fault flag high needed to declare a fault (must be >= 1)
CNT_WIDTH, 8, width of the saturating fault-event counter

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
fault_detected_i  in  1  registered parity mismatch from the checker
reg_write_i  in  1  any regfile write accepted this cycle
trigger_i  in  1  job-start request, single-cycle pulse
clear_i  in  1  software fault acknowledge
trigger_o  out  1  forwarded job start (combinational gate of trigger_i)
trigger_dropped_o  out  1  registered pulse, one cycle after a trigger_i that was not forwarded
fault_o  out  1  sticky fault flag
irq_o  out  1  one-cycle pulse on fault entry
armed_o  out  1  high while state is CHECK
fault_cnt_o  out  CNT_WIDTH  saturating count of fault entries

Behaviour:
- State machine: SETTLE, CHECK, FAULT.
- Internal counters: settle_cnt (width clog2(SETTLE_CYCLES+1)) and filt_cnt (width clog2(FILTER_LEN+1)).
- Reset values: state=SETTLE, settle_cnt=SETTLE_CYCLES, filt_cnt=0. All outputs 0 (fault_o, irq_o, trigger_dropped_o, armed_o, fault_cnt_o; trigger_o=0 since state is not CHECK).
- SETTLE:
  - fault_detected_i ignored; filt_cnt held at 0.
  - reg_write_i=1: reload settle_cnt=SETTLE_CYCLES.
  - Otherwise, if settle_cnt==1, go to CHECK; else decrement settle_cnt.
  - Net effect: CHECK is entered exactly SETTLE_CYCLES write-free cycles after the last write (or after reset).
- CHECK (priority order):
  - reg_write_i=1: go to SETTLE, settle_cnt=SETTLE_CYCLES, filt_cnt=0. A fault flag in the same cycle is ignored.
  - Else, fault_detected_i=1 and filt_cnt==FILTER_LEN-1: go to FAULT, filt_cnt=0.
  - Else, fault_detected_i=1: filt_cnt++.
  - Else: filt_cnt=0.
- FAULT:
  - fault_o=1; reg_write_i and fault_detected_i are ignored.
  - clear_i=1: go to SETTLE with settle_cnt=SETTLE_CYCLES; fault_o drops the next cycle.
- clear_i in SETTLE or CHECK has no effect.
- irq_o: registered, high for exactly the one cycle after the CHECK->FAULT transition edge, i.e. the same cycle fault_o first rises.
- fault_cnt_o: increments by 1 on each CHECK->FAULT transition. Saturates at 2^CNT_WIDTH-1 (no wrap). Cleared only by reset.
- trigger_o = trigger_i & (state==CHECK) & ~fault_detected_i & ~reg_write_i. Zero-latency combinational gate.
- trigger_dropped_o: registered. High the cycle after trigger_i=1 with trigger_o=0. This includes a trigger coincident with clear_i while in FAULT, which is dropped.
- armed_o = (state==CHECK), driven from the state register.
- Asynchronous reset mid-operation: returns immediately to reset values; the fault count is lost.
- Elaboration assertions: SETTLE_CYCLES>=1, FILTER_LEN>=1, CNT_WIDTH>=1.

Test Plan:
- Parameters used unless stated: SETTLE_CYCLES=2, FILTER_LEN=2, CNT_WIDTH=2.
- Reset, no writes -> armed_o rises on the 2nd clock edge after reset release. Then trigger_i pulse -> trigger_o=1 in the same cycle; trigger_dropped_o stays 0.
- Writes on cycles 10,11,12 with fault_detected_i=1 from cycle 10 to 13 -> no fault_o, no irq_o. armed_o rises at cycle 15. A trigger_i at cycle 13 -> trigger_o=0 and trigger_dropped_o=1 at cycle 14.
- In CHECK, fault_detected_i high for 1 cycle, low, then high for 2 cycles -> fault_o and irq_o rise the cycle after the 2nd consecutive high. irq_o lasts 1 cycle; fault_cnt_o=1; armed_o=0.
- In FAULT, send reg_write_i plus trigger_i -> fault_o stays 1, trigger_o=0, trigger_dropped_o pulses. Then clear_i -> fault_o=0 next cycle, armed_o returns 2 cycles later.
- Four fault/clear cycles -> fault_cnt_o goes 1,2,3,3 (saturation). irq_o pulses 4 times.
- Reset asserted while in FAULT with fault_cnt_o=2 -> all outputs 0 immediately; after release the block behaves as in the first scenario.
